// File: rtl/rs232_pkg.sv
// ----------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS232 receive and transmit sides.
//
// Contents:
//   DEFAULT_CLKS_PER_BIT : clock cycles per UART bit (50 MHz / 115200 baud)
//   DATA_W               : UART payload width
//   BAUD_CNT_W           : width of the baud counter (covers up to 65535)
//   rs232_state_e        : receiver FSM state encoding
//   even_parity()        : parity bit that makes the total count of ones even
//
// Optional feature macro: RS232_RX_PARITY_EN adds the PARITY state.
// ----------------------------------------------------------------------------
package rs232_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_W               = 8;
    localparam int BAUD_CNT_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RS232_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rs232_state_e;

    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rs232_rx_if.sv
// ----------------------------------------------------------------------------
// rs232_rx_if
// Bundles the serial line input and the received-byte outputs of rs232_rx.
//
// Signals:
//   i_rx         : serial line, idle high, asynchronous to the receiver clock
//   o_data       : last received byte (held between o_valid pulses)
//   o_valid      : one-cycle pulse, new byte on o_data
//   o_busy       : receiver is inside a frame
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_parity_err : one-cycle pulse, parity mismatch (RS232_RX_PARITY_EN only)
//
// Modports:
//   master : the receiver (consumes i_rx, drives the outputs)
//   slave  : line driver / byte consumer side
//
// Optional feature macro: RS232_RX_PARITY_EN adds o_parity_err.
// ----------------------------------------------------------------------------
interface rs232_rx_if;
    import rs232_pkg::*;

    logic              i_rx;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_busy;
    logic              o_frame_err;
`ifdef RS232_RX_PARITY_EN
    logic              o_parity_err;

    modport master (
        input  i_rx,
        output o_data,
        output o_valid,
        output o_busy,
        output o_frame_err,
        output o_parity_err
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_valid,
        input  o_busy,
        input  o_frame_err,
        input  o_parity_err
    );
`else
    modport master (
        input  i_rx,
        output o_data,
        output o_valid,
        output o_busy,
        output o_frame_err
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_valid,
        input  o_busy,
        input  o_frame_err
    );
`endif

endinterface

// File: rtl/rs232_baud_cnt.sv
// ----------------------------------------------------------------------------
// rs232_baud_cnt
// Free-running bit-period counter for the RS232 receiver.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   load      : reload the counter to 0 (priority over counting)
//   half_tick : counter is on the last cycle of a half bit period
//   full_tick : counter is on the last cycle of a full bit period
//
// The counter wraps from CLKS_PER_BIT-1 to 0, so it never exceeds
// CLKS_PER_BIT-1. The ticks are decodes of the registered count.
// ----------------------------------------------------------------------------
module rs232_baud_cnt
    import rs232_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic half_tick,
    output logic full_tick
);

    localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [BAUD_CNT_W-1:0] FULL_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_CNT_W-1:0] CNT_ONE   = BAUD_CNT_W'(1);

    logic [BAUD_CNT_W-1:0] cnt_r;

    // Bit-period counter: reload on request, otherwise count and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {BAUD_CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= {BAUD_CNT_W{1'b0}};
        end else if (cnt_r == FULL_LAST) begin
            cnt_r <= {BAUD_CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign half_tick = (cnt_r == HALF_LAST);
    assign full_tick = (cnt_r == FULL_LAST);

endmodule

// File: rtl/rs232_rx.sv
// ----------------------------------------------------------------------------
// rs232_rx
// UART receiver, 8 data bits LSB first, 1 stop bit (optionally even parity).
//
// Parameters:
//   CLKS_PER_BIT : i_clk cycles per bit, legal 4..65535
//
// Ports:
//   i_clk : system clock, rising edge
//   i_rst : asynchronous active-low reset
//   bus   : rs232_rx_if.master (i_rx in; o_data, o_valid, o_busy,
//           o_frame_err and, with parity, o_parity_err out)
//
// Optional feature macro: RS232_RX_PARITY_EN inserts a PARITY state after
// the data bits and drives o_parity_err on a mismatch (byte is dropped).
//
// The line passes through a two-flop synchronizer; a third flop keeps the
// previous synchronized value so only a true 1->0 edge starts a frame and a
// line held low (break) never retriggers. Each frame is sampled mid-bit:
// half a bit after the start edge, then once per bit period.
// ----------------------------------------------------------------------------
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    rs232_rx_if.master  bus
);

    localparam int                  BIT_CNT_W = $clog2(DATA_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);

    logic                 run_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    rs232_state_e         state_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [DATA_W-1:0]    shift_r;
    logic [DATA_W-1:0]    data_r;
    logic                 valid_r;
    logic                 busy_r;
    logic                 frame_err_r;
`ifdef RS232_RX_PARITY_EN
    logic                 parity_err_r;
    logic                 parity_bad_r;
`endif

    logic                 half_tick_s;
    logic                 full_tick_s;
    logic                 sample_s;
    logic                 baud_load_s;
    logic                 fall_edge_s;
    logic                 frame_ok_s;

    // Reset release: the receiver becomes active one clock after i_rst rises.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Line synchronizer plus previous-value flop for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= bus.i_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign fall_edge_s = rx_prev_r & ~rx_sync_r;

    // Sample strobe per state; the baud counter is held at 0 in IDLE and
    // reloaded on every sample, so each state starts a fresh bit period.
    always_comb begin
        sample_s = 1'b0;
        case (state_r)
            ST_START:  sample_s = half_tick_s;
            ST_DATA:   sample_s = full_tick_s;
`ifdef RS232_RX_PARITY_EN
            ST_PARITY: sample_s = full_tick_s;
`endif
            ST_STOP:   sample_s = full_tick_s;
            default:   sample_s = 1'b0;
        endcase
        baud_load_s = ~run_r | (state_r == ST_IDLE) | sample_s;
    end

    // A byte is delivered only when nothing upstream of the stop bit failed.
    always_comb begin
`ifdef RS232_RX_PARITY_EN
        frame_ok_s = ~parity_bad_r;
`else
        frame_ok_s = 1'b1;
`endif
    end

    rs232_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .load      (baud_load_s),
        .half_tick (half_tick_s),
        .full_tick (full_tick_s)
    );

    // Receive FSM with registered outputs; busy follows the next state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {BIT_CNT_W{1'b0}};
            shift_r      <= {DATA_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parity_err_r <= 1'b0;
            parity_bad_r <= 1'b0;
`endif
        end else if (!run_r) begin
            state_r      <= ST_IDLE;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (fall_edge_s) begin
                        state_r      <= ST_START;
                        bit_cnt_r    <= {BIT_CNT_W{1'b0}};
                        busy_r       <= 1'b1;
`ifdef RS232_RX_PARITY_EN
                        parity_bad_r <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (sample_s) begin
                        if (rx_sync_r) begin
                            // Line back high mid start bit: a glitch, drop it.
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_s) begin
                        shift_r   <= {rx_sync_r, shift_r[DATA_W-1:1]};
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == LAST_BIT) begin
`ifdef RS232_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef RS232_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample_s) begin
                        state_r <= ST_STOP;
                        if (rx_sync_r != even_parity(shift_r)) begin
                            parity_err_r <= 1'b1;
                            parity_bad_r <= 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (sample_s) begin
                        // Leave in the sample cycle so a back-to-back start
                        // edge later in the stop bit is still seen.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        if (!rx_sync_r) begin
                            frame_err_r <= 1'b1;
                        end else if (frame_ok_s) begin
                            data_r  <= shift_r;
                            valid_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data       = data_r;
    assign bus.o_valid      = valid_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_frame_err  = frame_err_r;
`ifdef RS232_RX_PARITY_EN
    assign bus.o_parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_rs232_rx.sv
// ----------------------------------------------------------------------------
// tb_rs232_rx
// Self-checking bench for rs232_rx at CLKS_PER_BIT = 8: a table of single
// frames, hand-written corner sequences (back-to-back, glitch, break, reset
// mid-frame) and a randomized frame stream checked against a frame-level
// reference model. Honors RS232_RX_PARITY_EN when defined.
// ----------------------------------------------------------------------------
module tb_rs232_rx;
    import rs232_pkg::*;

    localparam int CPB = 8;
`ifdef RS232_RX_PARITY_EN
    localparam int  PAR_BITS = 1;
    localparam logic PAR_EN  = 1'b1;
`else
    localparam int  PAR_BITS = 0;
    localparam logic PAR_EN  = 1'b0;
`endif
    // Busy lasts half a bit into the start bit, then data (+parity) and stop.
    localparam int FRAME_BUSY = CPB / 2 + (DATA_W + PAR_BITS + 1) * CPB;
    localparam int GAP        = 3 * CPB;

    logic clk = 1'b0;
    logic rst_n;

    rs232_rx_if bus_if ();

    rs232_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor).
    logic [7:0] got_q[$];
    int   ferr_cnt    = 0;
    int   perr_cnt    = 0;
    int   busy_cycles = 0;
    int   overlap_cnt = 0;
    int   consec_cnt  = 0;
    logic prev_pulse  = 1'b0;

    always @(negedge clk) begin : monitor
        logic pulse_now;
        logic perr_now;
`ifdef RS232_RX_PARITY_EN
        perr_now = bus_if.o_parity_err;
`else
        perr_now = 1'b0;
`endif
        pulse_now = bus_if.o_valid | bus_if.o_frame_err | perr_now;
        if (bus_if.o_valid) got_q.push_back(bus_if.o_data);
        if (bus_if.o_frame_err) ferr_cnt++;
        if (perr_now) perr_cnt++;
        if (bus_if.o_busy) busy_cycles++;
        if (bus_if.o_valid && (bus_if.o_frame_err || perr_now)) overlap_cnt++;
        if (pulse_now && prev_pulse) consec_cnt++;
        prev_pulse = pulse_now;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        bus_if.i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus_if.i_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par_ok ? ^d : ~^d);
        send_bit(stop);
    endtask

    // One frame followed by an idle gap, then all effects compared.
    task automatic run_frame(input string name, input logic [7:0] d, input logic par_ok,
                             input logic stop, input logic exp_valid, input logic exp_ferr,
                             input logic exp_perr, input logic [7:0] exp_hold);
        int v0, f0, p0, b0;
        v0 = got_q.size(); f0 = ferr_cnt; p0 = perr_cnt; b0 = busy_cycles;
        send_frame(d, par_ok, stop);
        idle(GAP);
        check({name, "_valid_cnt"}, 32'(got_q.size() - v0), 32'(exp_valid));
        if (exp_valid && got_q.size() > v0) check({name, "_data"}, 32'(got_q[v0]), 32'(d));
        check({name, "_ferr_cnt"}, 32'(ferr_cnt - f0), 32'(exp_ferr));
        if (PAR_EN) check({name, "_perr_cnt"}, 32'(perr_cnt - p0), 32'(exp_perr));
        check({name, "_busy_len"}, 32'(busy_cycles - b0), 32'(FRAME_BUSY));
        check({name, "_hold"}, 32'(bus_if.o_data), 32'(exp_hold));
        check({name, "_busy_end"}, 32'(bus_if.o_busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_ok;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr;
        logic [7:0] exp_hold;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        logic [7:0] d5;
        logic [7:0] model_last;
        logic [7:0] exp_q[$];
        int v0, f0, p0, b0, exp_ferr, exp_perr, nframes;

        // Frame table: data, parity ok, stop, then expected valid/ferr/perr/held o_data.
        vecs[0] = '{8'h23, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h23};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h23};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        // Wrong parity drops the byte only when parity is built in.
        vecs[6] = '{8'h23, 1'b0, 1'b1, ~PAR_EN, 1'b0, PAR_EN, (PAR_EN ? 8'hA5 : 8'h23)};
        vecs[7] = '{8'h23, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h23};

        bus_if.i_rx = 1'b1;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(bus_if.o_data),      32'd0);
        check("rst_valid", 32'(bus_if.o_valid),     32'd0);
        check("rst_busy",  32'(bus_if.o_busy),      32'd0);
        check("rst_ferr",  32'(bus_if.o_frame_err), 32'd0);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par_ok, vecs[i].stop,
                      vecs[i].exp_valid, vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].exp_hold);
        end

        // Back-to-back frames with no idle gap.
        v0 = got_q.size(); f0 = ferr_cnt; b0 = busy_cycles;
        send_frame(8'hAB, 1'b1, 1'b1);
        send_frame(8'h5D, 1'b1, 1'b1);
        idle(GAP);
        check("b2b_cnt", 32'(got_q.size() - v0), 32'd2);
        if (got_q.size() >= v0 + 2) begin
            check("b2b_first",  32'(got_q[v0]),     32'h0000_00AB);
            check("b2b_second", 32'(got_q[v0 + 1]), 32'h0000_005D);
        end
        check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("b2b_busy_len", 32'(busy_cycles - b0), 32'(2 * FRAME_BUSY));

        // Two-cycle low glitch on an idle line.
        v0 = got_q.size(); f0 = ferr_cnt; b0 = busy_cycles;
        bus_if.i_rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(GAP);
        check("glitch_busy_len", 32'(busy_cycles - b0), 32'(CPB / 2));
        check("glitch_valid", 32'(got_q.size() - v0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_busy_end", 32'(bus_if.o_busy), 32'd0);

        // Break: one frame error, then no retrigger while the line stays low.
        v0 = got_q.size(); f0 = ferr_cnt; p0 = perr_cnt; b0 = busy_cycles;
        bus_if.i_rx = 1'b0;
        repeat (3 * FRAME_BUSY) @(negedge clk);
        idle(GAP);
        check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("break_valid", 32'(got_q.size() - v0), 32'd0);
        check("break_perr", 32'(perr_cnt - p0), 32'd0);
        check("break_busy_len", 32'(busy_cycles - b0), 32'(FRAME_BUSY));
        check("break_hold", 32'(bus_if.o_data), 32'h0000_005D);

        // Reset in the middle of data bit 4 of 0x5D, then resend.
        run_frame("pre_rst", 8'h23, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h23);
        d5 = 8'h5D;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d5[i]);
        bus_if.i_rx = d5[4];
        repeat (CPB / 2) @(negedge clk);
        check("midrst_busy_before", 32'(bus_if.o_busy), 32'd1);
        v0 = got_q.size(); f0 = ferr_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data",  32'(bus_if.o_data),      32'd0);
        check("midrst_valid", 32'(bus_if.o_valid),     32'd0);
        check("midrst_busy",  32'(bus_if.o_busy),      32'd0);
        check("midrst_ferr",  32'(bus_if.o_frame_err), 32'd0);
        bus_if.i_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(GAP);
        check("postrst_valid", 32'(got_q.size() - v0), 32'd0);
        check("postrst_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("postrst_busy", 32'(bus_if.o_busy), 32'd0);
        run_frame("resend", 8'h5D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5D);

        // Randomized stream against a frame-level model.
        model_last = 8'h5D;
        exp_ferr = 0; exp_perr = 0; nframes = 24;
        v0 = got_q.size(); f0 = ferr_cnt; p0 = perr_cnt; b0 = busy_cycles;
        for (int k = 0; k < nframes; k++) begin
            logic [7:0] d;
            logic stop, par_ok;
            int gap;
            d      = 8'($urandom_range(0, 255));
            stop   = ($urandom_range(0, 5) != 0);
            par_ok = PAR_EN ? ($urandom_range(0, 4) != 0) : 1'b1;
            gap    = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
            if (!stop && gap < CPB) gap = CPB;
            if (!stop) exp_ferr++;
            if (!par_ok) exp_perr++;
            if (stop && par_ok) begin
                exp_q.push_back(d);
                model_last = d;
            end
            send_frame(d, par_ok, stop);
            idle(gap);
        end
        idle(GAP);
        check("rand_valid_cnt", 32'(got_q.size() - v0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (v0 + i < got_q.size())
                check($sformatf("rand_data%0d", i), 32'(got_q[v0 + i]), 32'(exp_q[i]));
        end
        check("rand_ferr_cnt", 32'(ferr_cnt - f0), 32'(exp_ferr));
        if (PAR_EN) check("rand_perr_cnt", 32'(perr_cnt - p0), 32'(exp_perr));
        check("rand_busy_len", 32'(busy_cycles - b0), 32'(nframes * FRAME_BUSY));
        check("rand_hold", 32'(bus_if.o_data), 32'(model_last));

        check("pulse_overlap", 32'(overlap_cnt), 32'd0);
        check("pulse_consecutive", 32'(consec_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs232_rx.md
RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, i_clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 i_clk  input  1  single system clock; all logic on rising edge.
REQ-003 i_rst  input  1  asynchronous, active-low reset.
REQ-004 i_rx  input  1  serial line, idle high, asynchronous to i_clk.
REQ-005 o_data  output  8  last received byte, LSB-first assembled; feeds downstream Flip i_data.
REQ-006 o_valid  output  1  one-cycle pulse, new byte on o_data; feeds downstream Flip i_start.
REQ-007 o_busy  output  1  high whenever state is not IDLE.
REQ-008 o_frame_err  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-009 i_rx SHALL pass through a 2-flop synchronizer, reset value 1; all sampling uses the synchronized value (2-cycle input latency).
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-011 IDLE -> START on synchronized falling edge (prev 1, now 0); bit counter cleared to 0.
REQ-012 START: after CLKS_PER_BIT/2 cycles (integer division), sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no outputs pulsed).
REQ-013 DATA: sample every CLKS_PER_BIT cycles, shift into bit (index) 0..7 LSB first; after 8th sample -> STOP (or PARITY).
REQ-014 STOP: sample after CLKS_PER_BIT cycles; 1 -> o_data updated, o_valid pulsed the following cycle; 0 -> o_frame_err pulsed, o_data unchanged, no o_valid; both -> IDLE.
REQ-015 o_valid and o_frame_err SHALL never be high in the same cycle, and never high two consecutive cycles.
REQ-016 o_data SHALL hold its value between o_valid pulses; no backpressure, consumer must accept on the pulse.
REQ-017 Baud counter SHALL reload to 0 on every sample and on every state entry; it SHALL never exceed CLKS_PER_BIT-1.
REQ-018 Return to IDLE from STOP takes effect in the sample cycle, so a start edge arriving immediately after a mid-stop sample is detected (back-to-back bytes, no gap needed).
REQ-019 Line held low in IDLE (break) SHALL NOT retrigger; a new falling edge is required.

Reset
REQ-020 i_rst low SHALL immediately force: state IDLE, counters 0, shift register 0, o_data 8'h00, o_valid 0, o_busy 0, o_frame_err 0, synchronizer flops 1.
REQ-021 Reset asserted mid-frame SHALL abandon the frame; no o_valid or error pulse on release.
REQ-022 Reset release SHALL be synchronized so the first active edge occurs 1 cycle after deassertion.

Configuration
REQ-023 Macro RS232_RX_PARITY_EN: defined -> PARITY state after 8 data bits samples even-parity bit; mismatch -> o_parity_err pulse (extra output port, width 1, reset 0) and no o_valid; STOP still sampled.
REQ-024 Undefined -> no PARITY state, no o_parity_err port, frame is 8N1.

Structure
REQ-025 Package rs232_pkg SHALL hold the FSM state enum, the default CLKS_PER_BIT constant and the 8-bit data-width constant; shared with the TX side.
REQ-026 One sub-module rs232_baud_cnt (counter with load/half/full-tick outputs) is natural; the FSM stays in rs232_rx.

Verification (CLKS_PER_BIT = 8)
REQ-027 Send 0x23 8N1 -> one o_valid pulse, o_data = 8'h23, o_busy high exactly for the frame.
REQ-028 Send 0xAB then 0x5D back-to-back, no idle gap -> two o_valid pulses, 0xAB then 0x5D, no errors.
REQ-029 Low glitch of 2 cycles on idle line -> o_busy pulses, no o_valid, no o_frame_err, returns to IDLE.
REQ-030 Send 0xFF with stop bit forced 0 -> o_frame_err one pulse, o_valid 0, o_data keeps previous value.
REQ-031 Assert i_rst during data bit 4 of 0x5D -> outputs reset immediately; resend 0x5D after release -> o_data = 8'h5D.
REQ-032 With RS232_RX_PARITY_EN: 0x23 with wrong parity 0 -> o_parity_err pulse, no o_valid; correct parity 1 -> o_valid, o_data = 8'h23.
